// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
// Block geometry here must agree with the cache arrays the controller feeds.
package cache_pkg;

    localparam int ADDR_W          = 16;
    localparam int BLOCK_BYTES     = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int OFF_W           = 3;
    localparam int CNT_W           = OFF_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Byte offset bits of a block are cleared; word fetches then never carry out of the block.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        block_base = {addr[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
    endfunction

    function automatic logic [ADDR_W-1:0] word_offset(input logic [CNT_W-1:0] idx);
        word_offset = ADDR_W'(idx) << 1;
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache/memory-side signal bundle of the miss-fill controller.
// The statistics outputs exist only when CACHE_FILL_STATS_EN is defined.
interface cache_fill_fsm_if;
    import cache_pkg::*;

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic              fsm_busy;
    logic              memory_req;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic [ADDR_W-1:0] data_array_addr;
    logic              write_tag_array;
`ifdef CACHE_FILL_STATS_EN
    logic [15:0]       fill_count;
    logic [15:0]       busy_cycles;

    modport master (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, memory_req, memory_address,
               write_data_array, data_array_addr, write_tag_array,
               fill_count, busy_cycles
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, memory_req, memory_address,
               write_data_array, data_array_addr, write_tag_array,
               fill_count, busy_cycles
    );
`else
    modport master (
        input  miss_detected, miss_address, memory_data_valid,
        output fsm_busy, memory_req, memory_address,
               write_data_array, data_array_addr, write_tag_array
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid,
        input  fsm_busy, memory_req, memory_address,
               write_data_array, data_array_addr, write_tag_array
    );
`endif

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: synchronous clear, increment enable, saturates at MAX.
module fill_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: fetches a whole block one word per cycle, writes each returned word,
// and writes the tag with the last word. Optional counters under CACHE_FILL_STATS_EN.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    cache_fill_fsm_if.master fill_if
);

    // state | meaning
    // IDLE  | waiting for a miss; memory returns are dropped
    // FILL  | issuing word requests and writing returned words

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  req_cnt, rcv_cnt;
    logic              cnt_clr;
    logic              busy, mem_req, wr_data, wr_tag;
    logic [ADDR_W-1:0] mem_addr, da_addr;

    fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_req_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (mem_req),
        .cnt_o (req_cnt)
    );

    fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (wr_data),
        .cnt_o (rcv_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (fill_if.miss_detected) begin
                    state_d = FILL;
                    base_d  = block_base(fill_if.miss_address);
                    cnt_clr = 1'b1;
                end
            end
            FILL: begin
                if (wr_tag) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses are forced to zero whenever their strobe cannot be active.
    always_comb begin
        busy     = (state_q == FILL);
        mem_req  = busy && (req_cnt < CNT_W'(WORDS_PER_BLOCK));
        mem_addr = mem_req ? (base_q + word_offset(req_cnt)) : '0;
        wr_data  = busy && fill_if.memory_data_valid;
        da_addr  = busy ? (base_q + word_offset(rcv_cnt)) : '0;
        wr_tag   = wr_data && (rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    end

    assign fill_if.fsm_busy         = busy;
    assign fill_if.memory_req       = mem_req;
    assign fill_if.memory_address   = mem_addr;
    assign fill_if.write_data_array = wr_data;
    assign fill_if.data_array_addr  = da_addr;
    assign fill_if.write_tag_array  = wr_tag;

`ifdef CACHE_FILL_STATS_EN
    logic [15:0] fill_count_q, busy_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_count_q  <= '0;
            busy_cycles_q <= '0;
        end else begin
            if (wr_tag && (fill_count_q != 16'hFFFF)) begin
                fill_count_q <= fill_count_q + 16'd1;
            end
            if (busy && (busy_cycles_q != 16'hFFFF)) begin
                busy_cycles_q <= busy_cycles_q + 16'd1;
            end
        end
    end

    assign fill_if.fill_count  = fill_count_q;
    assign fill_if.busy_cycles = busy_cycles_q;
`endif

endmodule
